base_initarb: RTL

//  Owns one memory write port and shares it between an internal init sweep and an external write stream.

---
 rtl/base_initarb.sv | 125 ++++++++++++
 1 files changed

// File: rtl/base_initarb.sv
// Write-port arbiter: sweeps INIT_VAL over every address (DEPTH-1 down to 0) after reset
// or reinit, then hands the single registered write slot to the external valid/ready stream.
module base_initarb #(
  parameter int               LOG_DEPTH = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reinit,
  output logic                 init_done,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [LOG_DEPTH-1:0] i_a,
  input  logic [WIDTH-1:0]     i_d,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [LOG_DEPTH-1:0] o_a,
  output logic [WIDTH-1:0]     o_d
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ILAST,
    ST_RUN,
    ST_RWAIT
  } state_e;

  localparam logic [LOG_DEPTH-1:0] COUNT_MAX = '1;

  state_e               state_q, state_d;
  logic [LOG_DEPTH-1:0] count_q, count_d;
  logic                 o_v_q, o_v_d;
  logic [LOG_DEPTH-1:0] o_a_q, o_a_d;
  logic [WIDTH-1:0]     o_d_q, o_d_d;
  logic                 free;
  logic                 ext_ready;

  // The slot can take a new beat when empty or when its current beat leaves this cycle.
  assign free = ~o_v_q | o_r;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d   = state_q;
    count_d   = count_q;
    o_v_d     = o_v_q & ~o_r;
    o_a_d     = o_a_q;
    o_d_d     = o_d_q;
    ext_ready = 1'b0;
    init_done = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        if (free) begin
          o_v_d = 1'b1;
          o_a_d = count_q;
          o_d_d = INIT_VAL;
          if (count_q == '0) begin
            state_d = ST_ILAST;
          end else begin
            count_d = count_q - LOG_DEPTH'(1);
          end
        end
      end

      ST_ILAST: begin
        if (o_v_q & o_r) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        init_done = 1'b1;
        ext_ready = free & ~reinit;
        if (reinit) begin
          // A held external beat must drain before the sweep, so ordering is preserved.
          if (free) begin
            count_d = COUNT_MAX;
            state_d = ST_INIT;
          end else begin
            state_d = ST_RWAIT;
          end
        end else if (i_v & ext_ready) begin
          o_v_d = 1'b1;
          o_a_d = i_a;
          o_d_d = i_d;
        end
      end

      ST_RWAIT: begin
        if (o_r) begin
          count_d = COUNT_MAX;
          state_d = ST_INIT;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      count_q <= COUNT_MAX;
      o_v_q   <= 1'b0;
      o_a_q   <= '0;
      o_d_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      o_v_q   <= o_v_d;
      o_a_q   <= o_a_d;
      o_d_q   <= o_d_d;
    end
  end

  assign i_r = ext_ready;
  assign o_v = o_v_q;
  assign o_a = o_a_q;
  assign o_d = o_d_q;

endmodule
